// File: rtl/usr_ms_shift_reg.sv
// Master-slave universal shift register with saturating shift counter and drained flag.
// Define USR_ROTATE_EN to make rot=1 turn shifts into rotates.
module usr_ms_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    localparam int              CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             Re,
    input  logic             inz,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             drained
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] master_r;
    logic [CNT_W-1:0] cnt_shadow_r;
    logic [WIDTH-1:0] master_next_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             msb_in_s;
    logic             lsb_in_s;

`ifdef USR_ROTATE_EN
    // Serial fill bits: wrap the opposite end of Q when rotating
    always_comb begin
        msb_in_s = sin_r;
        lsb_in_s = sin_l;
        if (rot) begin
            msb_in_s = Q[0];
            lsb_in_s = Q[WIDTH-1];
        end else begin
        end
    end
`else
    logic unused_rot_s;
    assign msb_in_s     = sin_r;
    assign lsb_in_s     = sin_l;
    assign unused_rot_s = rot;
`endif

    assign cnt_inc_s = (shift_cnt == CNT_MAX) ? CNT_MAX : shift_cnt + CNT_W'(1);

    // Next master/counter value; holding re-copies Q, which always equals the committed master
    always_comb begin
        master_next_s = Q;
        cnt_next_s    = shift_cnt;
        if (en) begin
            case (mode)
                2'b01: begin
                    master_next_s = {msb_in_s, Q[WIDTH-1:1]};
                    cnt_next_s    = cnt_inc_s;
                end
                2'b10: begin
                    master_next_s = {Q[WIDTH-2:0], lsb_in_s};
                    cnt_next_s    = cnt_inc_s;
                end
                2'b11: begin
                    master_next_s = D;
                    cnt_next_s    = {CNT_W{1'b0}};
                end
                default: begin
                    master_next_s = Q;
                    cnt_next_s    = shift_cnt;
                end
            endcase
        end else begin
            master_next_s = Q;
            cnt_next_s    = shift_cnt;
        end
    end

    // Master stage and counter shadow capture on the rising edge
    always_ff @(posedge clk or posedge Re) begin
        if (Re) begin
            master_r     <= RST_VAL;
            cnt_shadow_r <= {CNT_W{1'b0}};
        end else begin
            master_r     <= master_next_s;
            cnt_shadow_r <= cnt_next_s;
        end
    end

    // Slave stage commits on the falling edge; inz overrides the pending master value
    always_ff @(negedge clk or posedge Re) begin
        if (Re) begin
            Q         <= RST_VAL;
            shift_cnt <= {CNT_W{1'b0}};
            drained   <= 1'b0;
        end else if (inz) begin
            Q         <= {WIDTH{1'b0}};
            shift_cnt <= {CNT_W{1'b0}};
            drained   <= 1'b0;
        end else begin
            Q         <= master_r;
            shift_cnt <= cnt_shadow_r;
            drained   <= (cnt_shadow_r == CNT_MAX);
        end
    end

    assign sout_r = Q[0];
    assign sout_l = Q[WIDTH-1];

endmodule

// File: tb/tb_usr_ms_shift_reg.sv
// Directed bench for usr_ms_shift_reg (WIDTH=8, RST_VAL=8'hA5) with hand-computed expectations.
module tb_usr_ms_shift_reg;

    logic       clk;
    logic       Re;
    logic       inz;
    logic       en;
    logic [1:0] mode;
    logic       rot;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] D;
    logic [7:0] Q;
    logic       sout_r;
    logic       sout_l;
    logic [3:0] shift_cnt;
    logic       drained;

    int checks   = 0;
    int failures = 0;

    usr_ms_shift_reg #(.WIDTH(8), .RST_VAL(8'hA5)) dut (
        .clk(clk), .Re(Re), .inz(inz), .en(en), .mode(mode), .rot(rot),
        .sin_r(sin_r), .sin_l(sin_l), .D(D), .Q(Q), .sout_r(sout_r),
        .sout_l(sout_l), .shift_cnt(shift_cnt), .drained(drained)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then return just after the following negedge
    task automatic step(input logic e, input logic [1:0] m, input logic sr, input logic sl,
                        input logic [7:0] d, input logic z, input logic r);
        en = e; mode = m; sin_r = sr; sin_l = sl; D = d; inz = z; rot = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_q;
        Re = 1'b1; inz = 1'b0; en = 1'b0; mode = 2'b00; rot = 1'b0;
        sin_r = 1'b0; sin_l = 1'b0; D = 8'h00;
        #12;
        check("reset_q", 32'(Q), 32'h0000_00A5);
        check("reset_cnt", 32'(shift_cnt), 32'd0);
        check("reset_drained", 32'(drained), 32'd0);
        check("reset_sout_r", 32'(sout_r), 32'd1);
        check("reset_sout_l", 32'(sout_l), 32'd1);
        Re = 1'b0;

        // Load then one shift right
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);
        check("load81_q", 32'(Q), 32'h81);
        check("load81_cnt", 32'(shift_cnt), 32'd0);
        step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("shr_q", 32'(Q), 32'h40);
        check("shr_sout_r", 32'(sout_r), 32'd0);
        check("shr_cnt", 32'(shift_cnt), 32'd1);
        check("shr_drained", 32'(drained), 32'd0);

        // Hold (mode 00) and en=0 keep Q and counter
        step(1'b1, 2'b00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        check("hold_q", 32'(Q), 32'h40);
        check("hold_cnt", 32'(shift_cnt), 32'd1);
        step(1'b0, 2'b01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        check("en0_q", 32'(Q), 32'h40);
        check("en0_cnt", 32'(shift_cnt), 32'd1);

        // Ten left shifts filling ones; counter saturates at 8
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 2'b10, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            exp_q = (i >= 8) ? 8'hFF : 8'((1 << i) - 1);
            check($sformatf("shl%0d_q", i), 32'(Q), 32'(exp_q));
            check($sformatf("shl%0d_cnt", i), 32'(shift_cnt), (i >= 8) ? 32'd8 : 32'(i));
            check($sformatf("shl%0d_drained", i), 32'(drained), (i >= 8) ? 32'd1 : 32'd0);
        end
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0);
        check("reload_cnt", 32'(shift_cnt), 32'd0);
        check("reload_drained", 32'(drained), 32'd0);

        // Load with inz in the same cycle, then en=0 must not resurrect the load
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0);
        check("inz_load_q", 32'(Q), 32'h00);
        check("inz_load_cnt", 32'(shift_cnt), 32'd0);
        step(1'b0, 2'b11, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
        check("inz_en0_q", 32'(Q), 32'h00);

        // Unused serial input at X must not leak into Q
        step(1'b1, 2'b01, 1'b1, 1'bx, 8'h00, 1'b0, 1'b0);
        check("shr_fill_q", 32'(Q), 32'h80);
        step(1'b1, 2'b01, 1'b1, 1'bx, 8'h00, 1'b0, 1'b0);
        check("shr_x_q", 32'(Q), 32'hC0);
        check("shr_x_cnt", 32'(shift_cnt), 32'd2);
        step(1'b1, 2'b10, 1'bx, 1'b0, 8'h00, 1'b0, 1'b0);
        check("shl_x_q", 32'(Q), 32'h80);
        step(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        check("inz_shift_q", 32'(Q), 32'h00);
        check("inz_shift_cnt", 32'(shift_cnt), 32'd0);

        // Shift left with rot=1 from 8'h81
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0);
        step(1'b1, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
`ifdef USR_ROTATE_EN
        check("rot_shl_q", 32'(Q), 32'h03);
`else
        check("rot_shl_q", 32'(Q), 32'h02);
`endif
        check("rot_shl_cnt", 32'(shift_cnt), 32'd1);

        // Q must stay stable between posedge and negedge
        step(1'b1, 2'b11, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0);
        en = 1'b1; mode = 2'b01; sin_r = 1'b0; sin_l = 1'b0; rot = 1'b0;
        @(posedge clk);
        #1;
        check("half_before_q", 32'(Q), 32'h5A);
        check("half_before_cnt", 32'(shift_cnt), 32'd0);
        @(negedge clk);
        #1;
        check("half_after_q", 32'(Q), 32'h2D);
        check("half_after_cnt", 32'(shift_cnt), 32'd1);

        // Reset mid-cycle discards a pending load
        mode = 2'b11; D = 8'h0F;
        @(posedge clk);
        #1;
        Re = 1'b1;
        #1;
        check("midrst_q", 32'(Q), 32'hA5);
        check("midrst_cnt", 32'(shift_cnt), 32'd0);
        check("midrst_drained", 32'(drained), 32'd0);
        #1;
        Re = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_neg_q", 32'(Q), 32'hA5);
        step(1'b1, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("postrst_shr_q", 32'(Q), 32'h52);
        check("postrst_shr_cnt", 32'(shift_cnt), 32'd1);
        check("postrst_sout_l", 32'(sout_l), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
